// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for a 5-stage in-order core whose branches and
// register jumps resolve in ID.
//
// Detects load-use, ALU-to-branch and load-to-branch hazards and issues the
// needed stall cycles. A two-cycle stall uses the HOLD state. A data-memory
// wait freezes the pipeline and overrides everything else. Taken branches and
// jumps flush IF/ID. The block also keeps a stall-cycle performance counter
// and a sticky memory-wait watchdog.
//
// Ports
//   clk, rst_n                    clock, async active-low reset
//   id_rs1/2, id_use_rs1/2        ID sources and their use flags
//   branch, jalr, jump            ID control-flow class
//   branch_taken                  ID branch outcome
//   id_ex_rd/_reg_we/_mem_read    ID/EX producer info
//   ex_mem_rd/_reg_we/_mem_read   EX/MEM producer info
//   dmem_req, dmem_ready          data-memory handshake
//   pc_stall, if_id_stall         hold PC and IF/ID
//   if_id_flush, id_ex_flush      bubble IF/ID, bubble ID/EX
//   ex_stall, mem_wb_bubble       freeze controls used during a memory wait
//   haz_state, stall_cnt          FSM state (0=RUN, 1=HOLD), remaining stalls
//   mem_timeout                   sticky watchdog flag
//   stall_cycles                  count of cycles with pc_stall set
// -----------------------------------------------------------------------------
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        branch,
  input  logic        jalr,
  input  logic        jump,
  input  logic        branch_taken,
  input  logic [4:0]  id_ex_rd,
  input  logic        id_ex_reg_we,
  input  logic        id_ex_mem_read,
  input  logic [4:0]  ex_mem_rd,
  input  logic        ex_mem_reg_we,
  input  logic        ex_mem_mem_read,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_stall,
  output logic        mem_wb_bubble,
  output logic        haz_state,
  output logic [1:0]  stall_cnt,
  output logic        mem_timeout,
  output logic [15:0] stall_cycles
);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [1:0]  stall_cnt_q, stall_cnt_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;

  logic        mem_wait_s;
  logic        ctl_s;
  logic        match_ex_s;
  logic        match_mem_s;
  logic [1:0]  need_s;

  // A source matches a producer only if it is read and is not x0.
  function automatic logic src_match(input logic       use_src,
                                     input logic [4:0] rs,
                                     input logic [4:0] rd);
    return use_src && (rs != 5'd0) && (rs == rd);
  endfunction

  // Hazard detection, stall sequencing and output decode.
  always_comb begin
    state_d        = state_q;
    stall_cnt_d    = stall_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    mem_timeout_d  = mem_timeout_q;
    pc_stall       = 1'b0;
    if_id_stall    = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    ex_stall       = 1'b0;
    mem_wb_bubble  = 1'b0;

    mem_wait_s  = dmem_req && !dmem_ready;
    ctl_s       = branch || jalr;
    match_ex_s  = src_match(id_use_rs1, id_rs1, id_ex_rd) ||
                  src_match(id_use_rs2, id_rs2, id_ex_rd);
    match_mem_s = src_match(id_use_rs1, id_rs1, ex_mem_rd) ||
                  src_match(id_use_rs2, id_rs2, ex_mem_rd);

    // A load-use hazard dominates: it is the only one that can need 2 cycles.
    if (id_ex_reg_we && id_ex_mem_read && match_ex_s) begin
      need_s = ctl_s ? 2'd2 : 2'd1;
    end else if (ctl_s && ((id_ex_reg_we && !id_ex_mem_read && match_ex_s) ||
                           (ex_mem_reg_we && ex_mem_mem_read && match_mem_s))) begin
      need_s = 2'd1;
    end else begin
      need_s = 2'd0;
    end

    if (mem_wait_s) begin
      // Freeze everything; the stall sequence is paused, not advanced.
      pc_stall      = 1'b1;
      if_id_stall   = 1'b1;
      ex_stall      = 1'b1;
      mem_wb_bubble = 1'b1;
    end else begin
      case (state_q)
        HOLD: begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
          if (stall_cnt_q <= 2'd1) begin
            state_d     = RUN;
            stall_cnt_d = 2'd0;
          end else begin
            stall_cnt_d = stall_cnt_q - 2'd1;
          end
        end
        RUN: begin
          if (need_s != 2'd0) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
            if (need_s == 2'd2) begin
              state_d     = HOLD;
              stall_cnt_d = 2'd1;
            end else begin
              state_d = RUN;
            end
          end else if (jump || (branch && branch_taken)) begin
            if_id_flush = 1'b1;
          end else begin
            if_id_flush = 1'b0;
          end
        end
        default: begin
          state_d     = RUN;
          stall_cnt_d = 2'd0;
        end
      endcase
    end

    // Watchdog: saturate at 15, flag once a wait is still pending there.
    if (mem_wait_s) begin
      if (wait_cnt_q == 4'd15) begin
        mem_timeout_d = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + 4'd1;
      end
    end else begin
      wait_cnt_d = 4'd0;
    end

    stall_cycles_d = pc_stall ? (stall_cycles_q + 16'd1) : stall_cycles_q;
  end

  // State, watchdog and performance-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      stall_cnt_q    <= 2'd0;
      wait_cnt_q     <= 4'd0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      stall_cnt_q    <= stall_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign haz_state    = (state_q == HOLD);
  assign stall_cnt    = stall_cnt_q;
  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cycles_q;

endmodule
